// File: rtl/display_pkg.sv
// Shared display-path types and raster defaults for frame buffer scanout.
package display_pkg;

    localparam int unsigned PIXEL_W             = 24;
    localparam int unsigned DEF_COORD_W         = 10;
    localparam int unsigned BYTES_PER_PIXEL     = 3;
    localparam int unsigned DEF_PIXELS_PER_LINE = 110;
    localparam int unsigned DEF_LINES           = 110;

    typedef logic [PIXEL_W-1:0]     pixel_t;
    typedef logic [DEF_COORD_W-1:0] coord_t;
    typedef logic [1:0]             byte_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SEND
    } scan_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
    } pix_tag_t;

    // Byte 0 is the red channel, matching the write-path packing.
    function automatic logic [7:0] pixel_byte(input pixel_t p, input byte_idx_t idx);
        case (idx)
            2'd0:    return p[23:16];
            2'd1:    return p[15:8];
            default: return p[7:0];
        endcase
    endfunction

endpackage

// File: rtl/pixel_serializer.sv
// Holds the current and prefetched pixel words and streams the current one out as 3 bytes.
// FRAME_SCANOUT_SYNC_EN adds start-of-frame / end-of-line markers carried with each pixel.
module pixel_serializer
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        pf_cap_i,
    input  logic [23:0] mem_data_i,
`ifdef FRAME_SCANOUT_SYNC_EN
    input  logic        sof_tag_i,
    input  logic        eol_tag_i,
    output logic        byte_sof_o,
    output logic        byte_eol_o,
`endif
    input  logic        byte_ready_i,
    output logic [7:0]  byte_out_o,
    output logic        byte_valid_o,
    output logic        byte1_taken_o,
    output logic        pixel_done_o
);

    pixel_t    cur_q, cur_d, pf_q, pf_d;
    logic      pf_valid_q, pf_valid_d;
    byte_idx_t idx_q, idx_d;
    logic      valid_q, valid_d;
    logic      xfer, last_byte;

    assign xfer      = valid_q & byte_ready_i;
    assign last_byte = (idx_q == byte_idx_t'(BYTES_PER_PIXEL - 1));

    // A pixel boundary takes the prefetch register, or the word arriving this cycle.
    always_comb begin
        cur_d      = cur_q;
        pf_d       = pf_q;
        pf_valid_d = pf_valid_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        if (pf_cap_i) begin
            pf_d       = mem_data_i;
            pf_valid_d = 1'b1;
        end
        if (load_i) begin
            cur_d   = mem_data_i;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (xfer) begin
            if (!last_byte) begin
                idx_d = idx_q + 2'd1;
            end else begin
                idx_d = '0;
                if (pf_valid_q) begin
                    cur_d      = pf_q;
                    pf_valid_d = 1'b0;
                end else if (pf_cap_i) begin
                    cur_d      = mem_data_i;
                    pf_valid_d = 1'b0;
                end else begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q      <= '0;
            pf_q       <= '0;
            pf_valid_q <= 1'b0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            cur_q      <= cur_d;
            pf_q       <= pf_d;
            pf_valid_q <= pf_valid_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
        end
    end

    assign byte_out_o    = pixel_byte(cur_q, idx_q);
    assign byte_valid_o  = valid_q;
    assign byte1_taken_o = xfer & (idx_q == 2'd1);
    assign pixel_done_o  = xfer & last_byte;

`ifdef FRAME_SCANOUT_SYNC_EN
    pix_tag_t cur_tag_q, cur_tag_d, pf_tag_q, pf_tag_d;
    pix_tag_t tag_in;

    assign tag_in = '{sof: sof_tag_i, eol: eol_tag_i};

    always_comb begin
        cur_tag_d = cur_tag_q;
        pf_tag_d  = pf_tag_q;
        if (pf_cap_i) pf_tag_d = tag_in;
        if (load_i) begin
            cur_tag_d = tag_in;
        end else if (xfer && last_byte) begin
            if (pf_valid_q)    cur_tag_d = pf_tag_q;
            else if (pf_cap_i) cur_tag_d = tag_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_tag_q <= '0;
            pf_tag_q  <= '0;
        end else begin
            cur_tag_q <= cur_tag_d;
            pf_tag_q  <= pf_tag_d;
        end
    end

    assign byte_sof_o = valid_q & cur_tag_q.sof & (idx_q == 2'd0);
    assign byte_eol_o = valid_q & cur_tag_q.eol & last_byte;
`endif

endmodule

// File: rtl/frame_scanout.sv
// Frame buffer read side: raster walk, 1-cycle-latency pixel reads, byte serialization.
// FRAME_SCANOUT_SYNC_EN adds byte_sof/byte_eol framing outputs.
module frame_scanout
    import display_pkg::*;
#(
    parameter int unsigned PIXELS_PER_LINE = DEF_PIXELS_PER_LINE,
    parameter int unsigned LINES           = DEF_LINES,
    parameter int unsigned COORD_W         = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               mem_rd_en,
    output logic [COORD_W-1:0] mem_line,
    output logic [COORD_W-1:0] mem_px,
    input  logic [23:0]        mem_rd_data,
    output logic [7:0]         byte_out,
    output logic               byte_valid,
    input  logic               byte_ready,
`ifdef FRAME_SCANOUT_SYNC_EN
    output logic               byte_sof,
    output logic               byte_eol,
`endif
    output logic               frame_done
);

    localparam logic [COORD_W-1:0] PX_LAST   = COORD_W'(PIXELS_PER_LINE - 1);
    localparam logic [COORD_W-1:0] LINE_LAST = COORD_W'(LINES - 1);

    scan_state_t        state_q, state_d;
    logic [COORD_W-1:0] line_q, line_d, px_q, px_d;
    logic               last_issued_q, last_issued_d;
    logic               pf_issued_q, pf_issued_d;
    logic               rd_pend_q;
    logic               rd_en_c, frame_done_c;
    logic               byte1_taken, pixel_done;

    // line_q/px_q always hold the address of the next read to issue.
    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        px_d          = px_q;
        last_issued_d = last_issued_q;
        pf_issued_d   = pf_issued_q;
        rd_en_c       = 1'b0;
        frame_done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_FETCH;
                    line_d        = '0;
                    px_d          = '0;
                    last_issued_d = 1'b0;
                    pf_issued_d   = 1'b0;
                end
            end
            ST_FETCH: begin
                rd_en_c = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: state_d = ST_SEND;
            ST_SEND: begin
                if (byte1_taken && !last_issued_q) begin
                    rd_en_c     = 1'b1;
                    pf_issued_d = 1'b1;
                end
                if (pixel_done) begin
                    pf_issued_d = 1'b0;
                    if (!pf_issued_q) begin
                        frame_done_c = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rd_en_c) begin
            if (line_q == LINE_LAST && px_q == PX_LAST) begin
                last_issued_d = 1'b1;
            end else if (px_q == PX_LAST) begin
                px_d   = '0;
                line_d = line_q + COORD_W'(1);
            end else begin
                px_d = px_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            line_q        <= '0;
            px_q          <= '0;
            last_issued_q <= 1'b0;
            pf_issued_q   <= 1'b0;
            rd_pend_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            px_q          <= px_d;
            last_issued_q <= last_issued_d;
            pf_issued_q   <= pf_issued_d;
            rd_pend_q     <= rd_en_c;
        end
    end

`ifdef FRAME_SCANOUT_SYNC_EN
    logic sof_tag_q, eol_tag_q;

    // Markers ride alongside the read so they arrive with the returned pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            sof_tag_q <= 1'b0;
            eol_tag_q <= 1'b0;
        end else if (rd_en_c) begin
            sof_tag_q <= (line_q == '0) && (px_q == '0);
            eol_tag_q <= (px_q == PX_LAST);
        end
    end
`endif

    pixel_serializer u_ser (
        .clk           (clk),
        .reset         (reset),
        .load_i        (state_q == ST_WAIT),
        .pf_cap_i      (rd_pend_q && state_q == ST_SEND),
        .mem_data_i    (mem_rd_data),
`ifdef FRAME_SCANOUT_SYNC_EN
        .sof_tag_i     (sof_tag_q),
        .eol_tag_i     (eol_tag_q),
        .byte_sof_o    (byte_sof),
        .byte_eol_o    (byte_eol),
`endif
        .byte_ready_i  (byte_ready),
        .byte_out_o    (byte_out),
        .byte_valid_o  (byte_valid),
        .byte1_taken_o (byte1_taken),
        .pixel_done_o  (pixel_done)
    );

    assign busy       = (state_q != ST_IDLE);
    assign mem_rd_en  = rd_en_c;
    assign mem_line   = line_q;
    assign mem_px     = px_q;
    assign frame_done = frame_done_c;

endmodule
